// File: rtl/strip_trigger_load_scheduler_if.sv
// Candidate-in / serializer-load-out bundle for the strip trigger load scheduler.
// The scheduler takes the slave side; the band-ID stage and serializer sit on the master side.
interface strip_trigger_load_scheduler_if #(
  parameter int BCID_W = 12,
  parameter int BAND_W = 8,
  parameter int PHI_W  = 5
);
  logic              cand_valid;
  logic [BAND_W-1:0] cand_band_id;
  logic [BCID_W-1:0] cand_bcid;
  logic              ser_ready;
  logic              load;
  logic [BCID_W-1:0] out_bcid;
  logic [BAND_W-1:0] out_band_id;
  logic [PHI_W-1:0]  out_phi_id;

  modport slave (
    input  cand_valid, cand_band_id, cand_bcid, ser_ready,
    output load, out_bcid, out_band_id, out_phi_id
  );

  modport master (
    output cand_valid, cand_band_id, cand_bcid, ser_ready,
    input  load, out_bcid, out_band_id, out_phi_id
  );
endinterface

// File: rtl/strip_trigger_load_scheduler.sv
// Band-ID trigger-word scheduler: hold-off duplicate filter, FIFO buffering and
// one load per LOAD_PERIOD slot towards the strip trigger serializer.
module strip_trigger_load_scheduler #(
  parameter int BCID_W      = 12,
  parameter int BAND_W      = 8,
  parameter int PHI_W       = 5,
  parameter int DEPTH_LOG2  = 3,
  parameter int LOAD_PERIOD = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [7:0]            holdoff_bc,
  input  logic [PHI_W-1:0]      phi_id,
  strip_trigger_load_scheduler_if.slave bus,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [CNT_W-1:0]      drop_count,
  output logic [CNT_W-1:0]      dup_count
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int SLOT_W = (LOAD_PERIOD > 1) ? $clog2(LOAD_PERIOD) : 1;
  localparam logic [SLOT_W-1:0]   SLOT_LAST  = SLOT_W'(LOAD_PERIOD - 1);
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef struct packed {
    logic [PHI_W-1:0]  phi;
    logic [BCID_W-1:0] bcid;
    logic [BAND_W-1:0] band;
  } word_t;

  word_t                 mem [DEPTH];
  word_t                 head;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [SLOT_W-1:0]     slot_cnt;
  logic [7:0]            holdoff_cnt;
  logic [BAND_W-1:0]     last_band;
  logic                  qual, dup, accept, slot_edge, full, pop, push, drop;

  assign qual      = bus.cand_valid & enable;
  assign dup       = qual && (holdoff_cnt != 8'd0) && (bus.cand_band_id == last_band);
  assign accept    = qual && !dup;
  assign slot_edge = (slot_cnt == SLOT_LAST);
  assign full      = (fifo_level == LEVEL_FULL);
  // Pop looks only at the registered level, so a word written this edge cannot leave until the next.
  assign pop       = slot_edge && (fifo_level != '0) && bus.ser_ready;
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       slot_cnt <= '0;
    else if (slot_edge) slot_cnt <= '0;
    else                slot_cnt <= slot_cnt + SLOT_W'(1);
  end

  // A fresh acceptance reloads the window; duplicates do not extend it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holdoff_cnt <= '0;
      last_band   <= '0;
    end else if (accept) begin
      holdoff_cnt <= holdoff_bc;
      last_band   <= bus.cand_band_id;
    end else if (holdoff_cnt != 8'd0) begin
      holdoff_cnt <= holdoff_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (DEPTH_LOG2 + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (DEPTH_LOG2 + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{phi: phi_id, bcid: bus.cand_bcid, band: bus.cand_band_id};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.load        <= 1'b0;
      bus.out_bcid    <= '0;
      bus.out_band_id <= '0;
      bus.out_phi_id  <= '0;
    end else begin
      bus.load <= pop;
      if (pop) begin
        bus.out_bcid    <= head.bcid;
        bus.out_band_id <= head.band;
        bus.out_phi_id  <= head.phi;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
      dup_count  <= '0;
    end else begin
      if (drop && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
      if (dup  && (dup_count  != '1)) dup_count  <= dup_count  + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_strip_trigger_load_scheduler.sv
// Randomised scoreboard bench for strip_trigger_load_scheduler: a queue-based reference
// model predicts loads and per-edge status, a monitor compares them against the DUT.
module tb_strip_trigger_load_scheduler;
  localparam int P     = 4;
  localparam int DL    = 3;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable;
  logic [7:0]  holdoff_bc;
  logic [4:0]  phi_id;
  logic [DL:0] fifo_level;
  logic [CW-1:0] drop_count, dup_count;

  strip_trigger_load_scheduler_if #(.BCID_W(12), .BAND_W(8), .PHI_W(5)) bus_if ();

  strip_trigger_load_scheduler #(
    .BCID_W(12), .BAND_W(8), .PHI_W(5), .DEPTH_LOG2(DL), .LOAD_PERIOD(P), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .holdoff_bc(holdoff_bc), .phi_id(phi_id),
    .bus(bus_if.slave), .fifo_level(fifo_level), .drop_count(drop_count), .dup_count(dup_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  phi;
    logic [11:0] bcid;
    logic [7:0]  band;
  } word_t;
  typedef struct { int cyc; word_t w; } load_t;
  typedef struct { int level; int drop; int dup; word_t out; } stat_t;

  load_t load_q[$];
  stat_t stat_q[$];
  word_t m_fifo[$];
  int    m_acc_cyc, m_acc_hb, m_drop, m_dup, cyc;
  logic [7:0] m_last_band;
  word_t m_out;
  logic [7:0] cur_hb;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    load_q.delete();
    stat_q.delete();
    m_acc_cyc   = -100000;
    m_acc_hb    = 0;
    m_last_band = '0;
    m_drop      = 0;
    m_dup       = 0;
    m_out       = '0;
    cyc         = 0;
  endtask

  // Drive one cycle at a negedge, predict the coming edge, then move to the next negedge.
  task automatic step(input bit v, input logic [7:0] band, input logic [11:0] bcid,
                      input logic [4:0] phi, input bit en, input logic [7:0] hb, input bit rdy);
    bit slot, pop, qual, isdup;
    int sz;
    word_t w;
    bus_if.cand_valid   = v;
    bus_if.cand_band_id = band;
    bus_if.cand_bcid    = bcid;
    bus_if.ser_ready    = rdy;
    phi_id     = phi;
    enable     = en;
    holdoff_bc = hb;
    slot  = ((cyc % P) == P - 1);
    sz    = m_fifo.size();
    pop   = slot && (sz > 0) && rdy;
    qual  = v && en;
    isdup = qual && (band == m_last_band) && ((cyc - m_acc_cyc) <= m_acc_hb);
    if (pop) begin
      w = m_fifo.pop_front();
      m_out = w;
      load_q.push_back('{cyc, w});
    end
    if (isdup) begin
      if (m_dup < CMAX) m_dup++;
    end else if (qual) begin
      m_last_band = band;
      m_acc_cyc   = cyc;
      m_acc_hb    = hb;
      if (sz == DEPTH && !pop) begin
        if (m_drop < CMAX) m_drop++;
      end else begin
        m_fifo.push_back('{phi: phi, bcid: bcid, band: band});
      end
    end
    stat_q.push_back('{m_fifo.size(), m_drop, m_dup, m_out});
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit en, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 12'h000, 5'd0, en, cur_hb, rdy);
  endtask

  task automatic cand(input logic [7:0] band, input bit rdy);
    step(1'b1, band, 12'($urandom_range(0, 4095)), 5'($urandom_range(0, 31)), 1'b1, cur_hb, rdy);
  endtask

  // Monitor: compares per-edge status and pops an expected load whenever the DUT loads.
  initial begin
    int edges;
    stat_t s;
    load_t l;
    edges = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        edges = 0;
      end else begin
        if (stat_q.size() > 0) begin
          s = stat_q.pop_front();
          check("fifo_level", int'(fifo_level), s.level);
          check("drop_count", int'(drop_count), s.drop);
          check("dup_count",  int'(dup_count),  s.dup);
          check("out_band_id", int'(bus_if.out_band_id), int'(s.out.band));
          check("out_bcid",    int'(bus_if.out_bcid),    int'(s.out.bcid));
          check("out_phi_id",  int'(bus_if.out_phi_id),  int'(s.out.phi));
        end
        if (bus_if.load === 1'b1) begin
          if (load_q.size() == 0) begin
            check("unexpected_load", int'(bus_if.load), 0);
          end else begin
            l = load_q.pop_front();
            check("load_cycle", edges, l.cyc);
            check("load_band",  int'(bus_if.out_band_id), int'(l.w.band));
            check("load_bcid",  int'(bus_if.out_bcid),    int'(l.w.bcid));
            check("load_phi",   int'(bus_if.out_phi_id),  int'(l.w.phi));
          end
        end else if (load_q.size() > 0 && load_q[0].cyc <= edges) begin
          l = load_q.pop_front();
          check("missed_load_cycle", edges, l.cyc);
        end
        edges++;
      end
    end
  end

  initial begin
    bus_if.cand_valid   = 1'b0;
    bus_if.cand_band_id = '0;
    bus_if.cand_bcid    = '0;
    bus_if.ser_ready    = 1'b1;
    enable     = 1'b1;
    holdoff_bc = '0;
    phi_id     = '0;
    cur_hb     = '0;
    model_reset();

    // Reset held with candidates toggling: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_if.cand_valid   = ~bus_if.cand_valid;
      bus_if.cand_band_id = 8'(i + 1);
      #1;
      check("rst_load",  int'(bus_if.load), 0);
      check("rst_level", int'(fifo_level), 0);
      check("rst_drop",  int'(drop_count), 0);
      check("rst_dup",   int'(dup_count), 0);
      check("rst_band",  int'(bus_if.out_band_id), 0);
      check("rst_bcid",  int'(bus_if.out_bcid), 0);
      check("rst_phi",   int'(bus_if.out_phi_id), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Single candidate at cycle 0, load expected at the cycle-3 slot edge.
    step(1'b1, 8'h2A, 12'h123, 5'd5, 1'b1, 8'd0, 1'b1);
    idle(7, 1'b1, 1'b1);

    // Hold-off 4: band 0x10 at relative cycles 0, 2, 6; then the same with hold-off 0.
    for (int r = 0; r < 2; r++) begin
      cur_hb = (r == 0) ? 8'd4 : 8'd0;
      cand(8'h10, 1'b1); idle(1, 1'b1, 1'b1);
      cand(8'h10, 1'b1); idle(3, 1'b1, 1'b1);
      cand(8'h10, 1'b1); idle(16, 1'b1, 1'b1);
    end
    cur_hb = 8'd0;

    // Overflow: 10 back-to-back with no ready, then drain in order.
    for (int i = 0; i < 10; i++) cand(8'(8'h40 + i), 1'b0);
    idle(3, 1'b1, 1'b0);
    idle(40, 1'b1, 1'b1);

    // Full FIFO: push and pop land on the same slot edge.
    for (int i = 0; i < 8; i++) cand(8'(8'h60 + i), 1'b0);
    while ((cyc % P) != P - 1) idle(1, 1'b1, 1'b0);
    cand(8'h77, 1'b1);
    idle(40, 1'b1, 1'b1);

    // Ready only on alternate slot periods.
    for (int i = 0; i < 5; i++) cand(8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 48; i++) idle(1, 1'b1, ((cyc / P) % 2) == 0);

    // Asynchronous reset mid-burst, off the clock edge.
    for (int i = 0; i < 5; i++) cand(8'(8'h90 + i), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_load",  int'(bus_if.load), 0);
    check("midrst_level", int'(fifo_level), 0);
    check("midrst_band",  int'(bus_if.out_band_id), 0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;

    // Random traffic with a small band alphabet so duplicates and drops both occur.
    for (int i = 0; i < 1500; i++) begin
      cur_hb = 8'($urandom_range(0, 6));
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)),
           5'($urandom_range(0, 31)), $urandom_range(0, 7) != 0, cur_hb, $urandom_range(0, 3) != 0);
    end
    cur_hb = 8'd0;
    idle(40, 1'b0, 1'b1);

    // Saturation: plenty of drops with no ready, then plenty of duplicates.
    for (int i = 0; i < 30; i++) cand(8'(8'hA0 + i), 1'b0);
    idle(40, 1'b1, 1'b1);
    cur_hb = 8'd40;
    for (int i = 0; i < 20; i++) cand(8'hEE, 1'b1);
    cur_hb = 8'd0;
    idle(40, 1'b0, 1'b1);

    check("pending_loads",  load_q.size(), 0);
    check("pending_status", stat_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end
endmodule
